// File: rtl/pulse_meter_pkg.sv
// Shared state encoding and default sizing for the pulse_meter slice.
package pulse_meter_pkg;

    localparam int DEF_WIDTH_BITS = 9;
    localparam int DEF_MIN_CLOCKS = 2;
    localparam int DEF_THRESHOLD  = 16;
    localparam int DEF_MAX_CLOCKS = 511;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_WAITLOW = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_meter_pin_sync.sv
// Purpose: two-flop synchronizer for an asynchronous pin, idles high after reset.
// Latency: 2 clk from d to q, clocked every clk (not ce-gated).
// Backpressure: none; free-running level path.
module pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Purpose: measures high-pulse width on pin in ce ticks, classifies short/long, flags overflow.
// Latency: valid/overflow visible 1 clk after the detecting ce tick (+2 clk with PULSE_METER_SYNC_EN).
// Backpressure: none; valid/overflow are one-clk strobes, width/bitval hold until the next valid.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH_BITS = DEF_WIDTH_BITS,
    parameter int MIN_CLOCKS = DEF_MIN_CLOCKS,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int MAX_CLOCKS = DEF_MAX_CLOCKS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  pin,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  bitval,
    output logic                  valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [WIDTH_BITS-1:0] CNT_ONE = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0] MIN_CNT = WIDTH_BITS'(MIN_CLOCKS);
    localparam logic [WIDTH_BITS-1:0] THR_CNT = WIDTH_BITS'(THRESHOLD);
    localparam logic [WIDTH_BITS-1:0] MAX_CNT = WIDTH_BITS'(MAX_CLOCKS);

    logic                  pin_s;
    logic                  pinsample;
    logic                  rise;
    logic                  fall;
    state_t                state;
    logic [WIDTH_BITS-1:0] count;

`ifdef PULSE_METER_SYNC_EN
    pin_sync u_pin_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin),
        .q     (pin_s)
    );
`else
    assign pin_s = pin;
`endif

    assign rise = ~pinsample & pin_s;
    assign fall = pinsample & ~pin_s;

    // pinsample resets high so a line already high at release is not seen as a rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            pinsample <= 1'b1;
            width     <= '0;
            bitval    <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            if (ce) begin
                pinsample <= pin_s;
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_MEASURE;
                            count <= CNT_ONE;
                            busy  <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (pin_s) begin
                            if (count == MAX_CNT) begin
                                overflow <= 1'b1;
                                state    <= ST_WAITLOW;
                            end else begin
                                count <= count + CNT_ONE;
                            end
                        end else if (fall) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            // glitches below MIN_CNT leave the last result untouched
                            if (count >= MIN_CNT) begin
                                width  <= count;
                                bitval <= (count >= THR_CNT);
                                valid  <= 1'b1;
                            end
                        end
                    end
                    ST_WAITLOW: begin
                        if (!pin_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: expected strobes queued by stimulus, popped by a monitor.
module tb_pulse_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       pin;
    logic [8:0] width;
    logic       bitval;
    logic       valid;
    logic       overflow;
    logic       busy;

    typedef struct {
        bit ovf;
        int w;
        bit b;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    pulse_meter dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .pin      (pin),
        .width    (width),
        .bitval   (bitval),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_valid(input int w, input bit b);
        ev_t e;
        e.ovf = 1'b0;
        e.w   = w;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic expect_overflow();
        ev_t e;
        e.ovf = 1'b1;
        e.w   = 0;
        e.b   = 1'b0;
        sb.push_back(e);
    endtask

    // n ce ticks, each p clocks long with ce high only on the last clock
    task automatic ticks(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                ce = (j == p - 1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse(input int n, input int p);
        pin = 1'b1;
        ticks(n, p);
        pin = 1'b0;
        ticks(3, p);
    endtask

    always @(negedge clk) begin
        if (!reset && (valid || overflow)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: valid=%0b overflow=%0b width=%0d, expected no strobe",
                         valid, overflow, width);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_overflow", int'(overflow), int'(mon_e.ovf));
                chk("strobe_valid", int'(valid), int'(!mon_e.ovf));
                if (!mon_e.ovf) begin
                    chk("width", int'(width), mon_e.w);
                    chk("bitval", int'(bitval), int'(mon_e.b));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        pin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_width", int'(width), 0);
        chk("rst_bitval", int'(bitval), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);

        // line high through reset release is not a pulse
        reset = 1'b0;
        ticks(20, 1);
        chk("busy_high_at_release", int'(busy), 0);
        pin = 1'b0;
        ticks(3, 1);
        chk("busy_after_release_drop", int'(busy), 0);

        expect_valid(5, 1'b0);
        pulse(5, 1);
        expect_valid(15, 1'b0);
        pulse(15, 1);
        expect_valid(16, 1'b1);
        pulse(16, 1);

        // one-tick glitch is dropped and the last result holds
        pin = 1'b1;
        ticks(1, 1);
        chk("busy_glitch_high", int'(busy), 1);
        pin = 1'b0;
        ticks(1, 1);
        chk("busy_glitch_fall", int'(busy), 0);
        ticks(2, 1);
        chk("hold_width", int'(width), 16);
        chk("hold_bitval", int'(bitval), 1);

        // overflow on the 512th high tick
        expect_overflow();
        pin = 1'b1;
        ticks(511, 1);
        chk("ovf_before_512", int'(overflow), 0);
        chk("busy_long", int'(busy), 1);
        ticks(1, 1);
        chk("ovf_at_512", int'(overflow), 1);
        ticks(1, 1);
        chk("ovf_cleared", int'(overflow), 0);
        ticks(87, 1);
        chk("busy_waitlow", int'(busy), 1);
        pin = 1'b0;
        ticks(1, 1);
        chk("busy_after_ovf_fall", int'(busy), 0);
        ticks(2, 1);

        expect_valid(8, 1'b0);
        pulse(8, 1);

        expect_valid(10, 1'b0);
        pulse(10, 4);
        ce = 1'b1;

        // reset in the middle of a pulse
        pin = 1'b1;
        ticks(7, 1);
        chk("busy_mid_pulse", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_width", int'(width), 0);
        chk("midrst_bitval", int'(bitval), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ticks(12, 1);
        pin = 1'b0;
        ticks(3, 1);
        chk("busy_after_truncated", int'(busy), 0);

        expect_valid(12, 1'b0);
        pulse(12, 1);
        ticks(5, 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
